// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// The divide datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    // Wide enough for a 2*WIDTH product with WIDTH up to 64.
    localparam int ABS_W = 128;

    // Conditional two's-complement negate: gives |x| when neg marks x as negative,
    // and re-applies a sign to a magnitude on the way out.
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring divide step
// when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ACC_W = WIDTH + 1
) (
`ifdef MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] sh,
    input  logic [WIDTH-1:0] opnd,
    output logic [ACC_W-1:0] acc_nxt,
    output logic [WIDTH-1:0] sh_nxt
);

    // Multiply: {acc, sh} is the product register, shifted right once per step.
    logic [WIDTH:0]   sum;
    logic [ACC_W-1:0] mul_acc;
    logic [WIDTH-1:0] mul_sh;

    assign sum     = {1'b0, acc[WIDTH-1:0]} + (sh[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_acc = ACC_W'(sum[WIDTH:1]);
    assign mul_sh  = {sum[0], sh[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    // Divide: remainder stays below the divisor, so its top bit is always clear on entry.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_acc_msb;

    assign unused_acc_msb = acc[WIDTH];
    assign shifted        = {acc[WIDTH-1:0], sh[WIDTH-1]};
    assign diff           = shifted - {1'b0, opnd};
    assign acc_nxt        = is_div ? (diff[WIDTH] ? shifted : diff) : mul_acc;
    assign sh_nxt         = is_div ? {sh[WIDTH-2:0], ~diff[WIDTH]} : mul_sh;
`else
    assign acc_nxt = mul_acc;
    assign sh_nxt  = mul_sh;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divides flag div_by_zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_DIV_EN
    localparam int ACC_W = WIDTH + 1;
`else
    localparam int ACC_W = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    muldiv_state_t    state, state_nxt;
    muldiv_op_t       opc;
    logic             is_mul_req, is_div_req, sgn, acc_run, acc_fin;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] sh, sh_nxt, opnd;
    logic             neg_res, dz;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] res_hi, res_lo;
`ifdef MULDIV_DIV_EN
    logic             is_div, neg_rem;
`endif

    assign opc        = muldiv_op_t'(op);
    assign is_mul_req = (opc == OP_MULT) || (opc == OP_MULTU);
    assign is_div_req = (opc == OP_DIV) || (opc == OP_DIVU);
    assign sgn        = (opc == OP_MULT) || (opc == OP_DIV);
    assign a_mag      = WIDTH'(abs_val(ABS_W'(a), sgn & a[WIDTH-1]));
    assign b_mag      = WIDTH'(abs_val(ABS_W'(b), sgn & b[WIDTH-1]));

`ifdef MULDIV_DIV_EN
    assign acc_fin = (state == IDLE) && start && is_div_req && (b == '0);
    assign acc_run = (state == IDLE) && start && (is_mul_req || (is_div_req && (b != '0)));
`else
    assign acc_fin = (state == IDLE) && start && is_div_req;
    assign acc_run = (state == IDLE) && start && is_mul_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_run) state_nxt = RUN;
                     else if (acc_fin) state_nxt = FIN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign div_by_zero = (state == FIN) && dz;

    muldiv_step #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_step (
`ifdef MULDIV_DIV_EN
        .is_div  (is_div),
`endif
        .acc     (acc),
        .sh      (sh),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .sh_nxt  (sh_nxt)
    );

    // Result of the final step, with signs restored.
    always_comb begin
        prod   = PW'(abs_val(ABS_W'({acc_nxt[WIDTH-1:0], sh_nxt}), neg_res));
        res_hi = prod[PW-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            res_hi = WIDTH'(abs_val(ABS_W'(acc_nxt[WIDTH-1:0]), neg_rem));
            res_lo = WIDTH'(abs_val(ABS_W'(sh_nxt), neg_res));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            acc     <= '0;
            sh      <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            dz      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (opc == OP_MTHI) hi <= a;
                    if (opc == OP_MTLO) lo <= a;
                    dz <= acc_fin;
                    if (acc_run) begin
                        cnt     <= '0;
                        acc     <= '0;
                        neg_res <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sh      <= is_div_req ? a_mag : b_mag;
                        opnd    <= is_div_req ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
                        is_div  <= is_div_req;
                        neg_rem <= sgn & a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven bench for muldiv_unit (WIDTH=32) with a result scoreboard;
// expectations follow MULDIV_DIV_EN so either build can be checked.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dz;
        int          cyc, lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          cyc = 0, busy_run = 0, last_busy = 0, done_cnt = 0;
    logic [31:0] mdl_hi = '0, mdl_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: done=1 at cycle %0d, no result expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", div_by_zero, e.dz);
                chk("latency", cyc - e.cyc, e.lat);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic expect_done, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, output int n0);
        exp_t e;
        @(negedge clk);
        n0 = cyc;
        start = 1'b1; op = o; a = av; b = bv;
        if (expect_done) begin
            e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc; e.lat = edz ? 1 : 33;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), maxc);
            sb.delete();
        end
    endtask

    // Expected hi/lo are the divide-enabled answers; divides without the
    // divide datapath, or by zero, keep the previous HI/LO and raise the flag.
    task automatic run_op(input vec_t v);
        logic        is_div, dz;
        logic [31:0] eh, el;
        int          n0;
        is_div = (v.op == 3'd2) || (v.op == 3'd3);
`ifdef MULDIV_DIV_EN
        dz = is_div && (v.b == 32'd0);
`else
        dz = is_div;
`endif
        eh = dz ? mdl_hi : v.hi;
        el = dz ? mdl_lo : v.lo;
        issue(v.op, v.a, v.b, 1'b1, eh, el, dz, n0);
        mdl_hi = eh;
        mdl_lo = el;
        drain(60);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        vec_t v;
        int   n0, dc0;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[2]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[3]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[5]  = '{3'd0, 32'h00000005, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2};
        vecs[6]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{3'd3, 32'd5,        32'd10,       32'd5,        32'd0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        reset = 1'b0;

        // -3 * 7, with busy-window length
        v = '{3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
        run_op(v);
        repeat (2) @(negedge clk);
        chk("busy_cycles", last_busy, 33);

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // MTHI/MTLO then divide by zero keeps them
        issue(3'd4, 32'h11, 32'h0, 1'b0, '0, '0, 1'b0, n0);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", busy, 0);
        issue(3'd5, 32'h22, 32'h0, 1'b0, '0, '0, 1'b0, n0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_busy", busy, 0);
        mdl_hi = 32'h11;
        mdl_lo = 32'h22;
        v = '{3'd3, 32'd100, 32'd0, 32'd0, 32'd0};
        run_op(v);

        // reserved op: nothing happens
        issue(3'd6, 32'hDEAD, 32'hBEEF, 1'b0, '0, '0, 1'b0, n0);
        chk("rsvd_busy", busy, 0);
        chk("rsvd_hi", hi, mdl_hi);
        chk("rsvd_lo", lo, mdl_lo);

        // start while busy is dropped
        issue(3'd1, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 1'b0, n0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd30;
        while (cyc < n0 + 10) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        drain(60);
        v = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        run_op(v);

        // reset mid-multiply aborts with no done
        issue(3'd0, 32'h1234, 32'h5678, 1'b0, '0, '0, 1'b0, n0);
        while (cyc < n0 + 15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        mdl_hi = '0;
        mdl_lo = '0;
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt, dc0);

        v = '{3'd1, 32'd9, 32'd9, 32'd0, 32'd81};
        run_op(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
